// File: rtl/wb_stage.sv
// Write-back stage: selects and extends load data for the GPR write port,
// holds the HI/LO pair, forwards CP0 writes and counts retirements and loads.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst_n,
  input  logic [4:0]       wb_wa,
  input  logic             wb_wreg,
  input  logic [31:0]      wb_dreg,
  input  logic             wb_mreg,
  input  logic [3:0]       wb_dre,
  input  logic             wb_sign,
  input  logic             wb_whilo,
  input  logic [63:0]      wb_hilo,
  input  logic             wb_cp0_we,
  input  logic [4:0]       wb_cp0_waddr,
  input  logic [31:0]      wb_cp0_wdata,
  input  logic [31:0]      dm,
  input  logic             cnt_clr,
  output logic [4:0]       rf_wa,
  output logic             rf_we,
  output logic [31:0]      rf_wd,
  output logic [31:0]      hi_o,
  output logic [31:0]      lo_o,
  output logic             cp0_we,
  output logic [4:0]       cp0_waddr,
  output logic [31:0]      cp0_wdata,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] load_cnt
);

  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_load_cnt;
  logic [31:0]      w_load_data;
  logic             w_rf_we;
  logic             w_retire_evt;
  logic             w_load_evt;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
    return {{24{s & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
    return {{16{s & h[15]}}, h};
  endfunction

  // Lane selection; unsupported enable patterns yield zero.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_load_data = '0;
    case (wb_dre)
      4'b0001: w_load_data = ext8(dm[7:0], wb_sign);
      4'b0010: w_load_data = ext8(dm[15:8], wb_sign);
      4'b0100: w_load_data = ext8(dm[23:16], wb_sign);
      4'b1000: w_load_data = ext8(dm[31:24], wb_sign);
      4'b0011: w_load_data = ext16(dm[15:0], wb_sign);
      4'b1100: w_load_data = ext16(dm[31:16], wb_sign);
      4'b1111: w_load_data = dm;
      default: w_load_data = '0;
    endcase
  end

  // Register 0 is hard-wired, so writes to it are suppressed here.
  assign w_rf_we      = wb_wreg && (wb_wa != 5'd0);
  assign w_retire_evt = w_rf_we || wb_whilo || wb_cp0_we;
  assign w_load_evt   = wb_mreg && w_rf_we;

  assign rf_wa     = wb_wa;
  assign rf_we     = w_rf_we;
  assign rf_wd     = wb_mreg ? w_load_data : wb_dreg;
  assign cp0_we    = wb_cp0_we;
  assign cp0_waddr = wb_cp0_waddr;
  assign cp0_wdata = wb_cp0_wdata;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (wb_whilo) begin
      r_hi <= wb_hilo[63:32];
      r_lo <= wb_hilo[31:0];
    end
  end

  // Clear wins over a same-cycle increment; counters wrap freely.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_retire_cnt <= '0;
      r_load_cnt   <= '0;
    end else if (cnt_clr) begin
      r_retire_cnt <= '0;
      r_load_cnt   <= '0;
    end else begin
      if (w_retire_evt) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      if (w_load_evt)   r_load_cnt   <= r_load_cnt + CNT_W'(1);
    end
  end

  assign hi_o       = r_hi;
  assign lo_o       = r_lo;
  assign retire_cnt = r_retire_cnt;
  assign load_cnt   = r_load_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a behavioural model checked every cycle
// plus directed vectors with literal expectations.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  wa;
  logic        wreg;
  logic [31:0] dreg;
  logic        mreg;
  logic [3:0]  dre;
  logic        sign;
  logic        whilo;
  logic [63:0] hilo;
  logic        c_we;
  logic [4:0]  c_waddr;
  logic [31:0] c_wdata;
  logic [31:0] dm;
  logic        cnt_clr;

  logic [4:0]  rf_wa;
  logic        rf_we;
  logic [31:0] rf_wd;
  logic [31:0] hi_o, lo_o;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [31:0] retire_cnt, load_cnt;

  // Narrow-counter instance sharing all inputs, used to exercise wrap-around.
  logic [4:0]  s_rf_wa;
  logic        s_rf_we;
  logic [31:0] s_rf_wd, s_hi_o, s_lo_o, s_cp0_wdata;
  logic        s_cp0_we;
  logic [4:0]  s_cp0_waddr;
  logic [3:0]  s_retire_cnt, s_load_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .wb_wa(wa), .wb_wreg(wreg), .wb_dreg(dreg),
    .wb_mreg(mreg), .wb_dre(dre), .wb_sign(sign), .wb_whilo(whilo), .wb_hilo(hilo),
    .wb_cp0_we(c_we), .wb_cp0_waddr(c_waddr), .wb_cp0_wdata(c_wdata), .dm(dm),
    .cnt_clr(cnt_clr), .rf_wa(rf_wa), .rf_we(rf_we), .rf_wd(rf_wd), .hi_o(hi_o),
    .lo_o(lo_o), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .retire_cnt(retire_cnt), .load_cnt(load_cnt)
  );

  wb_stage #(.CNT_W(4)) dut_s (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .wb_wa(wa), .wb_wreg(wreg), .wb_dreg(dreg),
    .wb_mreg(mreg), .wb_dre(dre), .wb_sign(sign), .wb_whilo(whilo), .wb_hilo(hilo),
    .wb_cp0_we(c_we), .wb_cp0_waddr(c_waddr), .wb_cp0_wdata(c_wdata), .dm(dm),
    .cnt_clr(cnt_clr), .rf_wa(s_rf_wa), .rf_we(s_rf_we), .rf_wd(s_rf_wd), .hi_o(s_hi_o),
    .lo_o(s_lo_o), .cp0_we(s_cp0_we), .cp0_waddr(s_cp0_waddr), .cp0_wdata(s_cp0_wdata),
    .retire_cnt(s_retire_cnt), .load_cnt(s_load_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Load extraction from the lane rules using shift/mask arithmetic.
  function automatic logic [31:0] model_load(input logic [31:0] d, input logic [3:0] en,
                                             input logic s);
    int off, w;
    longint v;
    case (en)
      4'b0001: begin off = 0;  w = 8;  end
      4'b0010: begin off = 8;  w = 8;  end
      4'b0100: begin off = 16; w = 8;  end
      4'b1000: begin off = 24; w = 8;  end
      4'b0011: begin off = 0;  w = 16; end
      4'b1100: begin off = 16; w = 16; end
      4'b1111: return d;
      default: return 32'd0;
    endcase
    v = (longint'(d) >> off) % (longint'(1) << w);
    if (s && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return 32'(v);
  endfunction

  // Behavioural model of the architectural state.
  logic [31:0] m_hi, m_lo;
  longint      m_retire, m_load;
  logic        e_we, e_retire, e_load;
  assign e_we     = wreg && (wa != 5'd0);
  assign e_retire = e_we || whilo || c_we;
  assign e_load   = mreg && e_we;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_retire <= 0; m_load <= 0;
    end else begin
      if (whilo) begin
        m_hi <= hilo[63:32];
        m_lo <= hilo[31:0];
      end
      if (cnt_clr) begin
        m_retire <= 0; m_load <= 0;
      end else begin
        m_retire <= m_retire + (e_retire ? 1 : 0);
        m_load   <= m_load + (e_load ? 1 : 0);
      end
    end
  end

  always @(negedge clk) begin
    check("rf_wa", 64'(rf_wa), 64'(wa));
    check("rf_we", 64'(rf_we), 64'(e_we));
    check("rf_wd", 64'(rf_wd), 64'(mreg ? model_load(dm, dre, sign) : dreg));
    check("hi_o", 64'(hi_o), 64'(m_hi));
    check("lo_o", 64'(lo_o), 64'(m_lo));
    check("cp0", 64'({cp0_we, cp0_waddr, cp0_wdata}), 64'({c_we, c_waddr, c_wdata}));
    check("retire_cnt", 64'(retire_cnt), 64'(m_retire % (longint'(1) << 32)));
    check("load_cnt", 64'(load_cnt), 64'(m_load % (longint'(1) << 32)));
    check("retire_cnt4", 64'(s_retire_cnt), 64'(m_retire % 16));
    check("load_cnt4", 64'(s_load_cnt), 64'(m_load % 16));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa = '0; wreg = 0; dreg = '0; mreg = 0; dre = '0; sign = 0; whilo = 0; hilo = '0;
    c_we = 0; c_waddr = '0; c_wdata = '0; dm = '0; cnt_clr = 0;
  endtask

  logic [3:0]  dre_tab [5] = '{4'b0001, 4'b0001, 4'b1100, 4'b1111, 4'b0101};
  logic        sgn_tab [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] exp_tab [5] = '{32'hFFFFFF81, 32'h00000081, 32'hFFFF80F0, 32'h80F07F81, 32'h0};

  initial begin
    idle();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", 64'(hi_o), 64'h0);
    check("reset retire", 64'(retire_cnt), 64'h0);
    rst_n = 1'b1;
    step();

    // HI/LO write becomes visible after the edge.
    whilo = 1; hilo = 64'h1234_5678_9ABC_DEF0;
    step();
    whilo = 0; hilo = '0;
    check("t1 hi", 64'(hi_o), 64'h12345678);
    check("t1 lo", 64'(lo_o), 64'h9ABCDEF0);
    check("t1 retire", 64'(retire_cnt), 64'd1);

    // Load extraction patterns.
    mreg = 1; wreg = 1; wa = 5'd5; dm = 32'h80F0_7F81;
    for (int i = 0; i < 5; i++) begin
      dre = dre_tab[i]; sign = sgn_tab[i];
      @(negedge clk);
      check($sformatf("t2 rf_wd[%0d]", i), 64'(rf_wd), 64'(exp_tab[i]));
      step();
    end
    idle();
    check("t2 load_cnt", 64'(load_cnt), 64'd5);
    check("t2 retire", 64'(retire_cnt), 64'd6);

    // Write to register 0 is suppressed and does not retire.
    wreg = 1; wa = 5'd0; dreg = 32'hDEAD;
    @(negedge clk);
    check("t3 rf_we", 64'(rf_we), 64'd0);
    check("t3 rf_wd", 64'(rf_wd), 64'hDEAD);
    step();
    check("t3 retire", 64'(retire_cnt), 64'd6);

    // Simultaneous GPR, HI/LO and CP0 writes retire once.
    wa = 5'd3; whilo = 1; hilo = 64'hCAFE_0001_BEEF_0002; c_we = 1; c_waddr = 5'd12;
    c_wdata = 32'h1;
    @(negedge clk);
    check("t4 rf_we", 64'(rf_we), 64'd1);
    check("t4 cp0", 64'({cp0_we, cp0_waddr}), 64'({1'b1, 5'd12}));
    step();
    idle();
    check("t4 hi", 64'(hi_o), 64'hCAFE0001);
    check("t4 lo", 64'(lo_o), 64'hBEEF0002);
    check("t4 retire", 64'(retire_cnt), 64'd7);

    // Wrap on the 4-bit instance, then clear against an event.
    wreg = 1; wa = 5'd3;
    repeat (8) step();
    check("t5 retire4 max", 64'(s_retire_cnt), 64'hF);
    step();
    check("t5 retire4 wrap", 64'(s_retire_cnt), 64'h0);
    check("t5 retire32", 64'(retire_cnt), 64'd16);
    mreg = 1; dre = 4'b1111; cnt_clr = 1;
    step();
    idle();
    check("t5 clr retire", 64'(retire_cnt), 64'd0);
    check("t5 clr load", 64'(load_cnt), 64'd0);

    // Asynchronous reset mid-cycle.
    whilo = 1; hilo = {32'hAAAA, 32'h1};
    step();
    whilo = 0; wreg = 1; wa = 5'd7; mreg = 1; dre = 4'b1111; dm = 32'h5;
    step();
    idle();
    check("t6 pre hi", 64'(hi_o), 64'hAAAA);
    check("t6 pre retire", 64'(retire_cnt), 64'd2);
    check("t6 pre load", 64'(load_cnt), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    dreg = 32'h55;
    #1;
    check("t6 rst hi", 64'(hi_o), 64'h0);
    check("t6 rst lo", 64'(lo_o), 64'h0);
    check("t6 rst retire", 64'(retire_cnt), 64'h0);
    check("t6 rst load", 64'(load_cnt), 64'h0);
    check("t6 rst rf_wd", 64'(rf_wd), 64'h55);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle();
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage that consumes the MEM/WB pipeline register outputs and drives the general register file write port.
- Extracts and sign- or zero-extends load data from data-memory read data.
- Holds the architectural HI/LO register pair.
- Forwards CP0 write requests.
- Keeps two retirement performance counters, readable by debug logic.

Parameters:
CNT_W  32  width of both performance counters

Ports:
cpu_clk_50M  input  1  system clock, all state on rising edge
cpu_rst_n  input  1  asynchronous active-low reset
wb_wa  input  5  destination GPR address
wb_wreg  input  1  GPR write enable
wb_dreg  input  32  ALU/move result
wb_mreg  input  1  1 = result comes from memory (load)
wb_dre  input  4  load byte-lane enables
wb_sign  input  1  1 = sign-extend load, 0 = zero-extend
wb_whilo  input  1  HI/LO write enable
wb_hilo  input  64  {HI,LO} write data
wb_cp0_we  input  1  CP0 write enable
wb_cp0_waddr  input  5  CP0 register address
wb_cp0_wdata  input  32  CP0 write data
dm  input  32  data-memory read data, valid in WB cycle
cnt_clr  input  1  synchronous clear of both counters
rf_wa  output  5  GPR write address
rf_we  output  1  GPR write enable
rf_wd  output  32  GPR write data
hi_o  output  32  current HI
lo_o  output  32  current LO
cp0_we  output  1  CP0 write enable
cp0_waddr  output  5  CP0 address
cp0_wdata  output  32  CP0 data
retire_cnt  output  CNT_W  retirement count
load_cnt  output  CNT_W  load count

Behaviour:
- Reset (cpu_rst_n=0, asynchronous, takes effect immediately):
  - hi_o=0, lo_o=0, retire_cnt=0, load_cnt=0.
  - Combinational outputs follow their inputs during reset.
- GPR port (combinational, zero latency):
  - rf_wa=wb_wa.
  - rf_we = wb_wreg AND (wb_wa != 0).
  - rf_wd = wb_mreg ? load_data : wb_dreg.
- Load extraction: lane i = dm[8i+7:8i].
  - Byte loads:
    - 0001 selects lane0.
    - 0010 selects lane1.
    - 0100 selects lane2.
    - 1000 selects lane3.
    - Result is the byte extended to 32 bits.
  - Halfword loads:
    - 0011 selects dm[15:0].
    - 1100 selects dm[31:16].
    - Result is the halfword extended to 32 bits.
  - Word load: 1111 selects dm unchanged; wb_sign has no effect.
  - Extension: wb_sign=1 replicates the selected MSB; wb_sign=0 fills zeros.
  - Any other pattern, including 0000: load_data=0.
- HI/LO:
  - On a rising edge with wb_whilo=1: HI<=wb_hilo[63:32] and LO<=wb_hilo[31:0].
  - Otherwise HI and LO hold.
  - hi_o/lo_o show the register contents; a write becomes visible the cycle after the edge.
  - No internal bypass. EXE-stage forwarding from wb_* is the consumer's job.
- CP0: cp0_we, cp0_waddr and cp0_wdata are combinational copies of the wb_cp0_* inputs.
- Counters, evaluated each rising edge:
  - retire event = rf_we OR wb_whilo OR wb_cp0_we.
  - load event = wb_mreg AND rf_we.
  - Each counter increments by 1 on its event and wraps modulo 2^CNT_W with no saturation.
  - cnt_clr=1 forces both counters to 0 and overrides a same-cycle increment.
  - Reset dominates cnt_clr.
- Simultaneous events: wb_whilo, rf_we and wb_cp0_we in one cycle all take effect. retire_cnt still increments by exactly 1.
- Reset mid-operation: a pending HI/LO write on the edge coincident with reset assertion is lost.
- Flushed bubbles arrive with all enables 0 and therefore do not count or write.

Test Plan:
1. Reset, then release; wb_whilo=1, wb_hilo=64'h1234_5678_9ABC_DEF0 -> next cycle hi_o=32'h12345678 and lo_o=32'h9ABCDEF0; retire_cnt=1.
2. wb_mreg=1, wb_wreg=1, wb_wa=5, dm=32'h80F0_7F81:
   - dre=0001, sign=1 -> rf_wd=32'hFFFFFF81.
   - dre=0001, sign=0 -> rf_wd=32'h00000081.
   - dre=1100, sign=1 -> rf_wd=32'hFFFF80F0.
   - dre=1111 -> rf_wd=32'h80F07F81.
   - dre=0101 -> rf_wd=0.
   - load_cnt increments once per cycle held.
3. wb_wreg=1, wb_wa=0, wb_dreg=32'hDEAD -> rf_we=0; retire_cnt unchanged.
4. wb_wreg=1 (wa=3), wb_whilo=1 and wb_cp0_we=1 (waddr=12, wdata=32'h1) in one cycle -> rf_we=1, cp0_we=1, cp0_waddr=12; HI/LO updated; retire_cnt +1 only.
5. Preload by running to retire_cnt=32'hFFFFFFFF, then one retire event -> retire_cnt=0. cnt_clr=1 together with an event -> both counters 0.
6. Assert cpu_rst_n=0 asynchronously mid-cycle while hi_o=32'hAAAA and counters are non-zero -> hi_o, lo_o and both counters go to 0 before the next clock edge.
